ts_pkt_arbiter: RTL
===================

Name: ts_pkt_arbiter

Overview:
Shares one TS insertion slot stream between NUM_SRC packet sources, such as CA-message and PSI buffers. Each source uses the rdy/ack/valid/data/eop packet interface. On each downstream insertion opportunity (slot_req), the block grants one ready source round-robin, issues a one-cycle ack, and forwards that source's byte stream to a single output. It also checks packet length and aborts stalled transfers on timeout.

Parameters:
NUM_SRC, 2, number of requesting sources (2..4)
SRC_IDX_W, 1, width of source index (clog2 NUM_SRC, min 1)
PKT_LEN, 192, expected bytes per packet
TIMEOUT, 1024, max idle cycles between ack and first byte, or between consecutive bytes
GAP_CYCLES, 2, dead cycles after packet end before next grant (covers registered rdy refresh)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
slot_req  in  1  one-cycle pulse: downstream can accept one packet now
src_rdy  in  NUM_SRC  source i holds >=1 complete packet
src_ack  out  NUM_SRC  one-cycle pop strobe to granted source
src_valid  in  NUM_SRC  source i byte valid
src_data  in  8*NUM_SRC  source i byte, bits [8i+7:8i]
src_eop  in  NUM_SRC  source i last byte, qualified by src_valid[i]
out_valid  out  1  forwarded byte valid
out_data  out  8  forwarded byte
out_sop  out  1  first byte of packet
out_eop  out  1  last byte of packet (source eop, or forced on overrun)
out_src  out  SRC_IDX_W  index of granted source, stable while busy
busy  out  1  high from grant through end of GAP
err_pulse  out  1  one-cycle protocol error strobe

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; last_grant=NUM_SRC-1, so source 0 wins first; counters 0.
- FSM states: IDLE, ACK, WAIT, XFER, GAP.
- IDLE:
  - slot_req=1 and |src_rdy=1: pick the first ready index searching last_grant+1 upward with wrap. Set out_src and last_grant to it. Go to ACK.
  - slot_req with no ready source: slot dropped, no state change.
- ACK: src_ack[g]=1 for exactly this one cycle, all other bits 0. busy=1. Go to WAIT. timer=0.
- WAIT: timer increments each cycle.
  - src_valid[g]=1: go to XFER and process this byte as in XFER.
  - timer==TIMEOUT-1 with no valid: err_pulse, go to GAP.
- XFER, per src_valid[g] byte:
  - Forward the byte with registered latency 1: out_valid=1 and out_data=src_data[g] the next cycle.
  - out_sop=1 on the first byte. byte_cnt increments (9-bit). timer clears.
  - With src_eop[g]: out_eop=1. If byte_cnt+1 != PKT_LEN, err_pulse in the same cycle as out_eop. Go to GAP.
  - If byte PKT_LEN arrives without eop: forward it with out_eop forced, err_pulse, go to GAP.
  - Cycles without valid increment timer. At timer==TIMEOUT-1: err_pulse, go to GAP, no out_eop.
- GAP: count GAP_CYCLES, then IDLE. busy deasserts on entering IDLE.
- Sources other than g are ignored entirely: their valid, data and eop are never forwarded.
- src_eop without src_valid is ignored.
- Granted-source bytes arriving in GAP or IDLE are dropped and never reach the output.
- slot_req while busy is ignored, not queued.
- src_rdy is sampled only in IDLE. A stale rdy right after a packet is masked by GAP.
- err_pulse is never asserted for two consecutive cycles. On simultaneous eop and timeout, eop takes priority.
- Reset mid-packet: immediate return to reset values. No ack is reissued.

Test Plan:
- Source 0 rdy only, slot_req at t: src_ack[0] high at t+1 only. 192 valid bytes 0x00..0xBF with eop on the last byte give out_data identical, 1-cycle delayed, with out_sop on 0x00, out_eop on 0xBF, out_src=0 and no err_pulse.
- Both rdy, four slot_req each after the previous GAP: grants are 0,1,0,1. If source 1 alone stays rdy, consecutive grants are 1,1.
- Grant, then no src_valid: err_pulse exactly TIMEOUT cycles after WAIT entry, no out_valid, busy low GAP_CYCLES later. The next slot grants the other ready source.
- Eop on byte 100: out_eop on that byte plus err_pulse. Then 200 bytes without eop: byte 192 carries forced out_eop plus err_pulse, and bytes 193..200 are not forwarded.
- slot_req pulsed during XFER, and src_valid[1] toggling while source 0 is granted: no extra ack, output carries only source 0 data.
- rst asserted at byte 50: all outputs 0 asynchronously. After release, slot_req with source 0 rdy grants source 0.

Source files
------------

// File: rtl/ts_pkt_arbiter.sv
// Round-robin arbiter that shares one TS insertion slot stream between
// NUM_SRC packet sources. Each accepted slot grants one ready source, pops it
// with a single-cycle ack and forwards its bytes with one cycle of latency,
// while checking the packet length and aborting stalled transfers.
module ts_pkt_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int SRC_IDX_W  = 1,
  parameter int PKT_LEN    = 192,
  parameter int TIMEOUT    = 1024,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   slot_req,
  input  logic [NUM_SRC-1:0]     src_rdy,
  output logic [NUM_SRC-1:0]     src_ack,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [8*NUM_SRC-1:0]   src_data,
  input  logic [NUM_SRC-1:0]     src_eop,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [SRC_IDX_W-1:0]   out_src,
  output logic                   busy,
  output logic                   err_pulse
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACK  = 3'd1,
    ST_WAIT = 3'd2,
    ST_XFER = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SRC_IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [SRC_IDX_W-1:0]   out_src_q, out_src_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [8:0]             byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [NUM_SRC-1:0]     src_ack_q, src_ack_d;
  logic                   out_valid_q, out_valid_d;
  logic [7:0]             out_data_q, out_data_d;
  logic                   out_sop_q, out_sop_d;
  logic                   out_eop_q, out_eop_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic [SRC_IDX_W-1:0]   grant_s;
  logic                   g_valid_s;
  logic [7:0]             g_data_s;
  logic                   g_eop_s;
  logic                   last_byte_s;
  logic                   timeout_s;

  // First ready source strictly after the previous winner, wrapping around.
  function automatic logic [SRC_IDX_W-1:0] rr_pick(input logic [SRC_IDX_W-1:0] last,
                                                   input logic [NUM_SRC-1:0]   rdy);
    logic [SRC_IDX_W-1:0] sel;
    logic [NUM_SRC-1:0]   sh;
    logic                 found;
    int                   idx;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end else begin
        idx = idx + 0;
      end
      sh = rdy >> idx;
      if (!found && sh[0]) begin
        sel   = SRC_IDX_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  assign grant_s     = rr_pick(last_grant_q, src_rdy);
  assign last_byte_s = ((byte_cnt_q + 9'd1) == 9'(PKT_LEN));
  assign timeout_s   = (timer_q == TMR_W'(TIMEOUT - 1));

  // Select the granted source's byte lane; all other sources are ignored.
  always_comb begin
    g_valid_s = 1'b0;
    g_data_s  = 8'h00;
    g_eop_s   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      g_valid_s = (out_src_q == SRC_IDX_W'(i)) ? src_valid[i]       : g_valid_s;
      g_data_s  = (out_src_q == SRC_IDX_W'(i)) ? src_data[8*i +: 8] : g_data_s;
      g_eop_s   = (out_src_q == SRC_IDX_W'(i)) ? src_eop[i]         : g_eop_s;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= SRC_IDX_W'(NUM_SRC - 1);
      out_src_q    <= '0;
      timer_q      <= '0;
      byte_cnt_q   <= 9'd0;
      gap_cnt_q    <= '0;
      src_ack_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_src_q    <= out_src_d;
      timer_q      <= timer_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      src_ack_q    <= src_ack_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic plus grant, timer, byte and gap counters.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_src_d    = out_src_q;
    timer_d      = timer_q;
    byte_cnt_d   = byte_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (slot_req && (|src_rdy)) begin
          state_d      = ST_ACK;
          last_grant_d = grant_s;
          out_src_d    = grant_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_d    = ST_WAIT;
        timer_d    = '0;
        byte_cnt_d = 9'd0;
      end
      ST_WAIT, ST_XFER: begin
        if (g_valid_s) begin
          timer_d    = '0;
          byte_cnt_d = byte_cnt_q + 9'd1;
          if (g_eop_s || last_byte_s) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = ST_XFER;
          end
        end else if (timeout_s) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs: ack strobe, forwarded byte with sop/eop, busy and error.
  always_comb begin
    src_ack_d   = '0;
    out_valid_d = 1'b0;
    out_data_d  = 8'h00;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    err_d       = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_ACK) begin
          src_ack_d = {{(NUM_SRC-1){1'b0}}, 1'b1} << grant_s;
        end else begin
          src_ack_d = '0;
        end
      end
      ST_WAIT, ST_XFER: begin
        if (g_valid_s) begin
          out_valid_d = 1'b1;
          out_data_d  = g_data_s;
          out_sop_d   = (byte_cnt_q == 9'd0);
          if (g_eop_s) begin
            out_eop_d = 1'b1;
            err_d     = !last_byte_s;
          end else if (last_byte_s) begin
            // Overrun: close the packet ourselves and flag it.
            out_eop_d = 1'b1;
            err_d     = 1'b1;
          end else begin
            out_eop_d = 1'b0;
          end
        end else if (timeout_s) begin
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
        end
      end
      default: begin
        err_d = 1'b0;
      end
    endcase
  end

  assign src_ack   = src_ack_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_src   = out_src_q;
  assign busy      = busy_q;
  assign err_pulse = err_q;

endmodule
